// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide unit controller for the E stage.
// Computes mult/multu/div/divu results immediately into a pending HI/LO pair.
// A down-counter then models the unit latency, and the pending pair is
// committed to hi/lo when the counter reaches zero. mthi/mtlo write directly
// when the unit is idle.
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic        signed_op;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] rt_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Ops 0 (mult) and 2 (div) are signed; 1 and 3 are unsigned.
  assign signed_op = ~md_op[0];

  // Result datapath: signed ops are handled by sign-extension for the product
  // and by magnitude division with sign fix-up for the quotient/remainder.
  // Magnitude division makes 0x80000000 / -1 fall out naturally as
  // quotient 0x80000000, remainder 0. A zero divisor is replaced by one so
  // the divider never sees zero; that result is discarded at commit anyway.
  always_comb begin
    mul_a   = signed_op ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    mul_b   = signed_op ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    product = mul_a * mul_b;
    rs_neg  = signed_op & rs_val[31];
    rt_neg  = signed_op & rt_val[31];
    rs_mag  = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag  = rt_neg ? (32'd0 - rt_val) : rt_val;
    rt_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    q_mag   = rs_mag / rt_safe;
    r_mag   = rs_mag % rt_safe;
    quot    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = rs_neg ? (32'd0 - r_mag) : r_mag;
  end

  assign busy      = (cnt != '0);
  assign stall_req = d_md_use & (busy | (start & (md_op <= 4'd3)));

  // Counter, pending pair and committed HI/LO. Reset wins over everything;
  // while busy, every start is ignored and only the countdown/commit runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (md_op)
        4'd0, 4'd1: begin
          cnt     <= CNT_W'(MULT_CYC);
          pend_hi <= product[63:32];
          pend_lo <= product[31:0];
          pend_wr <= 1'b1;
        end
        4'd2, 4'd3: begin
          cnt     <= CNT_W'(DIV_CYC);
          pend_hi <= rem;
          pend_lo <= quot;
          pend_wr <= (rt_val != 32'd0);
        end
        4'd4: hi <= rs_val;
        4'd5: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule
